z_core_mul_unit: RTL and testbench

- Sequencing wrapper around the combinational 32x32 tree multiplier for the RISC-V M extension (MUL, MULH, MULHSU, MULHU).
- Sits between the execute-stage issue logic and writeback.
- Registers operands, drives the tree, selects the low or high product half, and holds the result under a valid/ready handshake.
- Two-stage pipeline, one operation per cycle sustained throughput.

---
 rtl/z_core_mul_unit.sv | 207 ++++++++++++++++++++
 tb/tb_z_core_mul_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_core_mul_unit.sv
// Two-stage sequencing wrapper around the 32x32 tree multiplier (RV32 M: MUL/MULH/MULHSU/MULHU).
// Define Z_CORE_MUL_FUSE_EN to add the product cache with single-cycle fused bypass and fuse_hit.

module z_core_mul_tree (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        op1_signed,
    input  logic        op2_signed,
    output logic [63:0] product
);
    logic [63:0] ext1;
    logic [63:0] ext2;

    // Low 64 bits of the extended product equal the exact signed/unsigned result
    always_comb begin
        ext1    = {{32{op1_signed & op1[31]}}, op1};
        ext2    = {{32{op2_signed & op2[31]}}, op2};
        product = ext1 * ext2;
    end
endmodule

module z_core_mul_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
`ifdef Z_CORE_MUL_FUSE_EN
    output logic             fuse_hit,
`endif
    output logic             busy
);
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_op1_q, s1_op1_d;
    logic [31:0]      s1_op2_q, s1_op2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic        s2_free, s1_adv, ready_c, accept, bypass, s2_load;
    logic        s1_sgn1, s1_sgn2;
    logic [63:0] product, ld_prod;
    logic [1:0]  ld_op;
    logic [TAG_W-1:0] ld_tag;

    always_comb begin
        s1_sgn1 = (s1_op_q != 2'b11);
        s1_sgn2 = !s1_op_q[1];
    end

    z_core_mul_tree u_tree (
        .op1       (s1_op1_q),
        .op2       (s1_op2_q),
        .op1_signed(s1_sgn1),
        .op2_signed(s1_sgn2),
        .product   (product)
    );

    always_comb begin
        s2_free = !s2_valid_q | out_ready;
        s1_adv  = s1_valid_q & s2_free;
        ready_c = !flush & (!s1_valid_q | s1_adv);
        accept  = in_valid & ready_c;
    end

`ifdef Z_CORE_MUL_FUSE_EN
    logic        c_valid_q, c_valid_d;
    logic [31:0] c_op1_q, c_op1_d;
    logic [31:0] c_op2_q, c_op2_d;
    logic [1:0]  c_sgn_q, c_sgn_d;
    logic [63:0] c_prod_q, c_prod_d;
    logic        hit_q, hit_d;
    logic [1:0]  in_sgn;

    // Bypass only with S1 empty, so it can never overtake an older op
    always_comb begin
        in_sgn = {in_op != 2'b11, !in_op[1]};
        bypass = accept & !s1_valid_q & s2_free & c_valid_q
               & (c_op1_q == in_op1) & (c_op2_q == in_op2)
               & (c_sgn_q == in_sgn);
        ld_prod = bypass ? c_prod_q : product;
        ld_op   = bypass ? in_op : s1_op_q;
        ld_tag  = bypass ? in_tag : s1_tag_q;
    end

    always_comb begin
        c_valid_d = c_valid_q;
        c_op1_d   = c_op1_q;
        c_op2_d   = c_op2_q;
        c_sgn_d   = c_sgn_q;
        c_prod_d  = c_prod_q;
        hit_d     = bypass;
        if (flush) begin
            c_valid_d = 1'b0;
        end else if (s1_adv) begin
            c_valid_d = 1'b1;
            c_op1_d   = s1_op1_q;
            c_op2_d   = s1_op2_q;
            c_sgn_d   = {s1_sgn1, s1_sgn2};
            c_prod_d  = product;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_valid_q <= 1'b0;
            c_op1_q   <= '0;
            c_op2_q   <= '0;
            c_sgn_q   <= '0;
            c_prod_q  <= '0;
            hit_q     <= 1'b0;
        end else begin
            c_valid_q <= c_valid_d;
            c_op1_q   <= c_op1_d;
            c_op2_q   <= c_op2_d;
            c_sgn_q   <= c_sgn_d;
            c_prod_q  <= c_prod_d;
            hit_q     <= hit_d;
        end
    end

    assign fuse_hit = hit_q;
`else
    always_comb begin
        bypass  = 1'b0;
        ld_prod = product;
        ld_op   = s1_op_q;
        ld_tag  = s1_tag_q;
    end
`endif

    always_comb begin
        s2_load    = !flush & (s1_adv | bypass);
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_op1_d   = s1_op1_q;
        s1_op2_d   = s1_op2_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        tag_d      = tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept & !bypass) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_op_d  = in_op;
            s1_op1_d = in_op1;
            s1_op2_d = in_op2;
            s1_tag_d = in_tag;
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
        if (s2_load) begin
            res_d = (ld_op == 2'b00) ? ld_prod[31:0] : ld_prod[63:32];
            tag_d = ld_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_op1_q   <= s1_op1_d;
            s1_op2_q   <= s1_op2_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            tag_q      <= tag_d;
        end
    end

    assign in_ready   = ready_c;
    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign busy       = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_z_core_mul_unit.sv
// Directed self-checking bench for z_core_mul_unit.
// Fused-bypass checks run when Z_CORE_MUL_FUSE_EN is defined.

module tb_z_core_mul_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef Z_CORE_MUL_FUSE_EN
    logic        fuse_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    z_core_mul_unit #(.TAG_W(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
`ifdef Z_CORE_MUL_FUSE_EN
        .fuse_hit  (fuse_hit),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_op1   = a;
        in_op2   = b;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", busy);
        end
        n_checks++;
        if (out_result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result got %h want 0", out_result);
        end
        n_checks++;
        if (out_tag !== 5'd0) begin
            n_fail++; $display("FAIL reset_tag got %h want 0", out_tag);
        end
`ifdef Z_CORE_MUL_FUSE_EN
        n_checks++;
        if (fuse_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_fuse_hit got %b want 0", fuse_hit);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_mul;
        drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd5);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid got %b want 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_valid got %b want 1", out_valid);
        end
        n_checks++;
        if (out_result !== 32'd42) begin
            n_fail++; $display("FAIL basic_result got %h want %h", out_result, 32'd42);
        end
        n_checks++;
        if (out_tag !== 5'd5) begin
            n_fail++; $display("FAIL basic_tag got %h want 5", out_tag);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_high_ops;
        logic [1:0]  ops [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 32'hFFFFFFFF, 32'h00000002, 5'(10 + i));
            tick();
            drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp[i]) begin
                n_fail++;
                $display("FAIL high_op%0d got v=%b %h want v=1 %h",
                         i, out_valid, out_result, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [4]   = '{32'd3, 32'h00010000, 32'hFFFFFFFE, 32'd0};
        logic [31:0] b [4]   = '{32'd5, 32'h00010000, 32'd3, 32'h00012345};
        logic [31:0] exp [4] = '{32'd15, 32'h0, 32'hFFFFFFFA, 32'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(1'b1, 2'b00, a[i], b[i], 5'(i + 1));
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready%0d got %b want 1", i, in_ready);
                end
            end else begin
                drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            end
            tick();
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_result !== exp[i-1]
                    || out_tag !== 5'(i)) begin
                    n_fail++;
                    $display("FAIL b2b_res%0d got v=%b %h t=%0d want v=1 %h t=%0d",
                             i - 1, out_valid, out_result, out_tag, exp[i-1], i);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd1);
        tick();
        drive(1'b1, 2'b00, 32'd4, 32'd5, 5'd2);
        tick();
        drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd3);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready%0d got %b want 0", c, in_ready);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd6 || out_tag !== 5'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b %h t=%0d want v=1 6 t=1",
                         c, out_valid, out_result, out_tag);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd20 || out_tag !== 5'd2) begin
            n_fail++;
            $display("FAIL bp_drain1 got v=%b %h t=%0d want v=1 14 t=2",
                     out_valid, out_result, out_tag);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL bp_drain2 got v=%b %h t=%0d want v=1 2a t=3",
                     out_valid, out_result, out_tag);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd7);
        tick();
        drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd8);
        tick();
        drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd9);
        flush = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre got ready=%b busy=%b want 0 1", in_ready, busy);
        end
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear got v=%b busy=%b want 0 0", out_valid, busy);
        end
        n_checks++;
        if (out_result !== 32'd9 || out_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL flush_data got %h t=%0d want 9 t=7", out_result, out_tag);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_accept got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_boundary;
        logic [1:0]  ops [2] = '{2'b01, 2'b11};
        logic [31:0] a [2]   = '{32'h80000000, 32'hFFFFFFFF};
        logic [31:0] exp [2] = '{32'h40000000, 32'hFFFFFFFE};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ops[i], a[i], a[i], 5'(20 + i));
            tick();
            drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp[i]) begin
                n_fail++;
                $display("FAIL boundary%0d got v=%b %h want v=1 %h",
                         i, out_valid, out_result, exp[i]);
            end
            tick();
        end
    endtask

`ifdef Z_CORE_MUL_FUSE_EN
    task automatic test_fuse;
        drive(1'b1, 2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd1);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        drive(1'b1, 2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd2);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h242D2080 || fuse_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL fuse_hit got v=%b %h hit=%b want v=1 242d2080 hit=1",
                     out_valid, out_result, fuse_hit);
        end
        tick();
        n_checks++;
        if (fuse_hit !== 1'b0) begin
            n_fail++; $display("FAIL fuse_pulse got %b want 0", fuse_hit);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd3);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (out_valid !== 1'b0 || fuse_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL fuse_flush got v=%b hit=%b want 0 0", out_valid, fuse_hit);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h242D2080) begin
            n_fail++;
            $display("FAIL fuse_flush_res got v=%b %h want v=1 242d2080",
                     out_valid, out_result);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_mul();
        test_high_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_boundary();
`ifdef Z_CORE_MUL_FUSE_EN
        test_fuse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
